// File: rtl/spi_weight_loader_pkg.sv
// Shared encodings for the SPI weight loader: commands, bank selects, frame fields, FSM states.
package spi_weight_loader_pkg;

  localparam logic [1:0] CMD_WRITE  = 2'b00;
  localparam logic [1:0] CMD_COMMIT = 2'b01;
  localparam logic [1:0] CMD_CLEAR  = 2'b10;
  localparam logic [1:0] CMD_NOP    = 2'b11;

  localparam logic [1:0] SEL_COS1 = 2'd0;
  localparam logic [1:0] SEL_SIN1 = 2'd1;
  localparam logic [1:0] SEL_COS2 = 2'd2;
  localparam logic [1:0] SEL_SIN2 = 2'd3;

  // Frame field positions (16-bit frame, MSB first on the wire)
  localparam int unsigned CMD_MSB  = 15;
  localparam int unsigned CMD_LSB  = 14;
  localparam int unsigned CH_MSB   = 13;
  localparam int unsigned CH_LSB   = 11;
  localparam int unsigned SEL_MSB  = 10;
  localparam int unsigned SEL_LSB  = 9;
  localparam int unsigned RSVD_MSB = 8;
  localparam int unsigned RSVD_LSB = 5;

  typedef enum logic [1:0] {StIdle, StShift, StExec} state_e;

  // Word index inside a flat bank: all channels of sel 0 first, then sel 1, ...
  function automatic int unsigned bank_idx(logic [1:0] sel, logic [2:0] ch, int unsigned nch);
    return 32'(sel) * nch + 32'(ch);
  endfunction

endpackage

// File: rtl/spi_weight_loader_sync.sv
// Multi-stage synchronizer with registered-history edge pulses for one async input.
module spi_sync_edge #(
  parameter int unsigned Stages   = 2,
  parameter logic        ResetVal = 1'b0
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise,
  output logic o_fall
);

  logic [Stages-1:0] r_sync;
  logic              r_prev;

  // Synchronizer chain plus one history flop; reset value avoids a false edge at release
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_sync <= {Stages{ResetVal}};
      r_prev <= ResetVal;
    end else begin
      r_sync <= {r_sync[Stages-2:0], i_async};
      r_prev <= r_sync[Stages-1];
    end
  end

  assign o_sync = r_sync[Stages-1];
  assign o_rise = r_sync[Stages-1] & ~r_prev;
  assign o_fall = ~r_sync[Stages-1] & r_prev;

endmodule

// File: rtl/spi_weight_loader.sv
// SPI weight loader: oversampled SPI frames write a shadow bank; a commit copies the
// shadow into the active bank on the next frame strobe so outputs never tear.
module spi_weight_loader
  import spi_weight_loader_pkg::*;
#(
  parameter int unsigned NCH         = 8,
  parameter int unsigned WW          = 5,
  parameter int unsigned FRAME_BITS  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              sclk,
  input  logic              ss,
  input  logic              mosi,
  input  logic              frame_strobe,
  output logic [NCH*WW-1:0] w_cos_1,
  output logic [NCH*WW-1:0] w_sin_1,
  output logic [NCH*WW-1:0] w_cos_2,
  output logic [NCH*WW-1:0] w_sin_2,
  output logic              commit_pending,
  output logic              load_done,
  output logic              frame_err,
  output logic [7:0]        err_cnt
);

  localparam int unsigned   BankW  = 4 * NCH * WW;
  localparam int unsigned   CntW   = $clog2(FRAME_BITS + 2);
  localparam logic [CntW-1:0] CntSat  = CntW'(FRAME_BITS + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(FRAME_BITS);

  logic w_sclk_rise, w_ss_sync, w_ss_rise, w_ss_fall, w_mosi_sync;
  logic w_unused_sclk_sync, w_unused_sclk_fall, w_unused_mosi_rise, w_unused_mosi_fall;

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_sclk (
    .i_clock  (clock),
    .i_reset_n(reset_n),
    .i_async  (sclk),
    .o_sync   (w_unused_sclk_sync),
    .o_rise   (w_sclk_rise),
    .o_fall   (w_unused_sclk_fall)
  );

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b1)) u_sync_ss (
    .i_clock  (clock),
    .i_reset_n(reset_n),
    .i_async  (ss),
    .o_sync   (w_ss_sync),
    .o_rise   (w_ss_rise),
    .o_fall   (w_ss_fall)
  );

  spi_sync_edge #(.Stages(SYNC_STAGES), .ResetVal(1'b0)) u_sync_mosi (
    .i_clock  (clock),
    .i_reset_n(reset_n),
    .i_async  (mosi),
    .o_sync   (w_mosi_sync),
    .o_rise   (w_unused_mosi_rise),
    .o_fall   (w_unused_mosi_fall)
  );

  state_e              r_state, w_state_next;
  logic [FRAME_BITS-1:0] r_shift;
  logic [CntW-1:0]     r_cnt;
  logic [BankW-1:0]    r_shadow, r_active;
  logic                r_commit_pending, r_load_done, r_frame_err;
  logic [7:0]          r_err_cnt;

  logic [1:0]  w_cmd, w_sel;
  logic [2:0]  w_ch;
  logic [WW-1:0] w_data;
  logic [31:0] w_base;
  logic        w_valid, w_exec, w_exec_ok, w_exec_bad, w_copy;
  logic        w_unused_rsvd;

  assign w_cmd         = r_shift[CMD_MSB:CMD_LSB];
  assign w_ch          = r_shift[CH_MSB:CH_LSB];
  assign w_sel         = r_shift[SEL_MSB:SEL_LSB];
  assign w_data        = r_shift[WW-1:0];
  assign w_unused_rsvd = ^r_shift[RSVD_MSB:RSVD_LSB];
  assign w_base        = bank_idx(w_sel, w_ch, NCH) * WW;

  assign w_valid    = (r_cnt == CntFull) && (32'(w_ch) < NCH);
  assign w_exec     = (r_state == StExec);
  assign w_exec_ok  = w_exec & w_valid;
  assign w_exec_bad = w_exec & ~w_valid;
  assign w_copy     = frame_strobe & r_commit_pending;

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= StIdle;
    else          r_state <= w_state_next;
  end

  // FSM next state: frame opens on ss fall, executes for one cycle after ss rise
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:  if (w_ss_fall) w_state_next = StShift;
      StShift: if (w_ss_rise) w_state_next = StExec;
      StExec:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Shift register and saturating bit counter
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (r_state == StIdle && w_ss_fall) begin
      r_shift <= '0;
      r_cnt   <= '0;
    end else if (r_state == StShift && w_sclk_rise && !w_ss_sync) begin
      r_shift <= {r_shift[FRAME_BITS-2:0], w_mosi_sync};
      if (r_cnt != CntSat) r_cnt <= r_cnt + CntW'(1);
    end
  end

  // Frame execution, commit handshake, strobe-aligned bank copy and error counting.
  // The copy reads r_shadow before any same-cycle write lands; a same-cycle COMMIT re-arms.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_shadow         <= '0;
      r_active         <= '0;
      r_commit_pending <= 1'b0;
      r_load_done      <= 1'b0;
      r_frame_err      <= 1'b0;
      r_err_cnt        <= '0;
    end else begin
      r_load_done <= w_copy;
      r_frame_err <= w_exec_bad;
      if (w_exec_bad && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      if (w_copy) begin
        r_active         <= r_shadow;
        r_commit_pending <= 1'b0;
      end
      if (w_exec_ok) begin
        unique case (w_cmd)
          CMD_WRITE:  r_shadow[w_base +: WW] <= w_data;
          CMD_COMMIT: r_commit_pending <= 1'b1;
          CMD_CLEAR:  r_shadow <= '0;
          CMD_NOP:    ;
          default:    ;
        endcase
      end
    end
  end

  assign w_cos_1        = r_active[32'(SEL_COS1) * NCH * WW +: NCH * WW];
  assign w_sin_1        = r_active[32'(SEL_SIN1) * NCH * WW +: NCH * WW];
  assign w_cos_2        = r_active[32'(SEL_COS2) * NCH * WW +: NCH * WW];
  assign w_sin_2        = r_active[32'(SEL_SIN2) * NCH * WW +: NCH * WW];
  assign commit_pending = r_commit_pending;
  assign load_done      = r_load_done;
  assign frame_err      = r_frame_err;
  assign err_cnt        = r_err_cnt;

endmodule

// File: tb/tb_spi_weight_loader.sv
// Scoreboard bench for spi_weight_loader: stimulus pushes expected load/error events,
// a negedge monitor pops and compares whenever load_done or frame_err fires.
`timescale 1ns/1ps
module tb_spi_weight_loader;

  localparam int NCH = 8;
  localparam int WW  = 5;
  localparam int BW  = 4 * NCH * WW;
  localparam logic [1:0] C_WRITE  = 2'b00;
  localparam logic [1:0] C_COMMIT = 2'b01;
  localparam logic [1:0] C_CLEAR  = 2'b10;

  logic clock = 1'b0, reset_n = 1'b0, sclk = 1'b0, ss = 1'b1, mosi = 1'b0, frame_strobe = 1'b0;
  logic [NCH*WW-1:0] w_cos_1, w_sin_1, w_cos_2, w_sin_2;
  logic commit_pending, load_done, frame_err;
  logic [7:0] err_cnt;
  logic [BW-1:0] bank_out;

  spi_weight_loader #(.NCH(NCH), .WW(WW), .FRAME_BITS(16), .SYNC_STAGES(2)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .sclk          (sclk),
    .ss            (ss),
    .mosi          (mosi),
    .frame_strobe  (frame_strobe),
    .w_cos_1       (w_cos_1),
    .w_sin_1       (w_sin_1),
    .w_cos_2       (w_cos_2),
    .w_sin_2       (w_sin_2),
    .commit_pending(commit_pending),
    .load_done     (load_done),
    .frame_err     (frame_err),
    .err_cnt       (err_cnt)
  );

  always #5 clock = ~clock;
  assign bank_out = {w_sin_2, w_cos_2, w_sin_1, w_cos_1};

  typedef struct packed {
    logic          is_load;
    logic [BW-1:0] bank;
    logic [7:0]    cnt;
  } exp_t;

  exp_t q[$];
  int n_checks = 0;
  int n_errors = 0;
  logic [BW-1:0] m_shadow = '0;
  logic [BW-1:0] m_active = '0;
  int m_err = 0;

  function automatic logic [15:0] fr(logic [1:0] cmd, int ch, int sel, logic [4:0] data);
    return {cmd, 3'(ch), 2'(sel), 4'b0000, data};
  endfunction

  task automatic chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic m_write(int ch, int sel, logic [4:0] data);
    m_shadow[(sel * NCH + ch) * WW +: WW] = data;
  endtask

  task automatic push_load();
    exp_t e;
    e.is_load = 1'b1;
    e.bank    = m_shadow;
    e.cnt     = 8'(m_err);
    m_active  = m_shadow;
    q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    if (m_err < 255) m_err++;
    e.is_load = 1'b0;
    e.bank    = m_active;
    e.cnt     = 8'(m_err);
    q.push_back(e);
  endtask

  // sclk runs at 1/8 of the system clock; returns on the negedge where ss is raised
  task automatic send_frame(input logic [31:0] val, input int nbits, input bit raise);
    @(negedge clock) ss = 1'b0;
    repeat (4) @(negedge clock);
    for (int i = 0; i < nbits; i++) begin
      mosi = val[nbits - 1 - i];
      repeat (4) @(negedge clock);
      sclk = 1'b1;
      repeat (4) @(negedge clock);
      sclk = 1'b0;
    end
    repeat (4) @(negedge clock);
    if (raise) ss = 1'b1;
  endtask

  task automatic settle();
    repeat (8) @(negedge clock);
  endtask

  task automatic strobe();
    @(negedge clock) frame_strobe = 1'b1;
    @(negedge clock) frame_strobe = 1'b0;
  endtask

  // Strobe lands on the EXEC cycle: ss rise -> 2 sync stages -> EXEC on the third cycle
  task automatic strobe_on_exec();
    repeat (3) @(negedge clock);
    frame_strobe = 1'b1;
    @(negedge clock) frame_strobe = 1'b0;
  endtask

  // Monitor: pops one expectation per DUT event
  always @(negedge clock) begin
    if (reset_n && (load_done || frame_err)) begin
      if (q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_event: load_done=%0b frame_err=%0b, none expected",
                 load_done, frame_err);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("event_kind", BW'({load_done, frame_err}), BW'(e.is_load ? 2'b10 : 2'b01));
        if (e.is_load) chk("load_bank", bank_out, e.bank);
        else           chk("err_cnt_on_err", BW'(err_cnt), BW'(e.cnt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clock);
    chk("reset_bank", bank_out, '0);
    chk("reset_flags", BW'({commit_pending, load_done, frame_err}), '0);
    chk("reset_err_cnt", BW'(err_cnt), '0);
    reset_n = 1'b1;
    settle();

    // Shadow-only write: active must hold through strobes
    m_write(3, 1, 5'h0B);
    send_frame(32'(fr(C_WRITE, 3, 1, 5'h0B)), 16, 1'b1);
    settle();
    for (int i = 0; i < 10; i++) begin
      strobe();
      chk("sin1_ch3_held", BW'(w_sin_1[3*WW +: WW]), '0);
    end

    // Four words then commit; all change on one edge
    for (int c = 0; c < 4; c++) begin
      m_write(c, 0, 5'(c + 1));
      send_frame(32'(fr(C_WRITE, c, 0, 5'(c + 1))), 16, 1'b1);
      settle();
    end
    send_frame(32'(fr(C_COMMIT, 0, 0, 5'h00)), 16, 1'b1);
    settle();
    chk("pending_set", BW'(commit_pending), BW'(1));
    repeat (20) @(negedge clock);
    chk("cos1_before_strobe", BW'(w_cos_1), '0);
    push_load();
    @(negedge clock) frame_strobe = 1'b1;
    @(negedge clock) frame_strobe = 1'b0;
    chk("pending_cleared", BW'(commit_pending), '0);
    chk("load_done_pulse", BW'(load_done), BW'(1));
    chk("cos1_updated", BW'(w_cos_1), BW'(m_active[0 +: NCH*WW]));
    chk("sin1_ch3_loaded", BW'(w_sin_1[3*WW +: WW]), BW'(5'h0B));
    @(negedge clock);
    chk("load_done_one_cycle", BW'(load_done), '0);

    // Short and long frames are rejected
    push_err();
    send_frame(32'(fr(C_WRITE, 5, 2, 5'h07)) >> 1, 15, 1'b1);
    settle();
    push_err();
    send_frame({15'b0, fr(C_WRITE, 6, 2, 5'h07), 1'b0}, 17, 1'b1);
    settle();
    chk("err_cnt_two", BW'(err_cnt), BW'(2));
    chk("bank_after_err", bank_out, m_active);

    // COMMIT executing with the strobe: no copy until next strobe
    m_write(7, 3, 5'h1F);
    send_frame(32'(fr(C_WRITE, 7, 3, 5'h1F)), 16, 1'b1);
    settle();
    send_frame(32'(fr(C_COMMIT, 0, 0, 5'h00)), 16, 1'b1);
    strobe_on_exec();
    settle();
    chk("coincident_commit_pending", BW'(commit_pending), BW'(1));
    chk("coincident_commit_no_copy", bank_out, m_active);
    push_load();
    strobe();
    settle();

    // WRITE executing with the copy: copy takes pre-write shadow
    send_frame(32'(fr(C_COMMIT, 0, 0, 5'h00)), 16, 1'b1);
    settle();
    push_load();
    m_write(0, 0, 5'h15);
    send_frame(32'(fr(C_WRITE, 0, 0, 5'h15)), 16, 1'b1);
    strobe_on_exec();
    settle();
    chk("write_vs_copy_old", BW'(w_cos_1[0 +: WW]), BW'(5'h01));
    send_frame(32'(fr(C_COMMIT, 0, 0, 5'h00)), 16, 1'b1);
    settle();
    push_load();
    strobe();
    settle();
    chk("write_vs_copy_new", BW'(w_cos_1[0 +: WW]), BW'(5'h15));

    // Reset mid-frame with a commit pending
    send_frame(32'(fr(C_COMMIT, 0, 0, 5'h00)), 16, 1'b1);
    settle();
    send_frame(32'(fr(C_WRITE, 1, 1, 5'h0A)), 8, 1'b0);
    reset_n = 1'b0;
    sclk = 1'b0;
    ss = 1'b1;
    m_shadow = '0;
    m_active = '0;
    m_err = 0;
    repeat (3) @(negedge clock);
    chk("midframe_reset_bank", bank_out, '0);
    chk("midframe_reset_flags", BW'({commit_pending, load_done, frame_err}), '0);
    chk("midframe_reset_err_cnt", BW'(err_cnt), '0);
    reset_n = 1'b1;
    settle();
    strobe();
    chk("no_copy_after_reset", bank_out, '0);
    m_write(2, 2, 5'h09);
    send_frame(32'(fr(C_WRITE, 2, 2, 5'h09)), 16, 1'b1);
    settle();
    send_frame(32'(fr(C_COMMIT, 0, 0, 5'h00)), 16, 1'b1);
    settle();
    push_load();
    strobe();
    settle();
    chk("post_reset_cos2_ch2", BW'(w_cos_2[2*WW +: WW]), BW'(5'h09));

    // CLEAR while pending delivers zeros
    m_write(4, 3, 5'h11);
    send_frame(32'(fr(C_WRITE, 4, 3, 5'h11)), 16, 1'b1);
    settle();
    send_frame(32'(fr(C_COMMIT, 0, 0, 5'h00)), 16, 1'b1);
    settle();
    m_shadow = '0;
    send_frame(32'(fr(C_CLEAR, 0, 0, 5'h00)), 16, 1'b1);
    settle();
    push_load();
    strobe();
    settle();
    chk("clear_bank_zero", bank_out, '0);

    // 300 glitch frames saturate the error counter
    for (int i = 0; i < 300; i++) begin
      push_err();
      @(negedge clock) ss = 1'b0;
      repeat (4) @(negedge clock);
      ss = 1'b1;
      repeat (6) @(negedge clock);
    end
    settle();
    chk("err_cnt_saturated", BW'(err_cnt), BW'(255));
    chk("scoreboard_drained", BW'(q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
